// File: rtl/kb_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: register map,
// STATUS bit positions, receive FSM states and the parity helper.
package kb_pkg;

  // Register select values, taken from mem_addr[3:2].
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CLEAR  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_FRM_ERR = 2;
  localparam int ST_PAR_ERR = 3;
  localparam int ST_OVF     = 4;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_scancode_mmio_if.sv
// Keyboard register port between the memory controller (master) and the
// PS/2 receiver (slave). Read-only: strobe, byte offset, combinational data.
interface ps2_scancode_mmio_if;
  logic        mem_read;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;

  modport master (output mem_read, output mem_addr, input mem_rdata);
  modport slave  (input mem_read, input mem_addr, output mem_rdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head. A push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign head  = mem[rd_ptr];

  // NOTE: storage is not reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_mmio.sv
// PS/2 device-to-host receiver: pin synchronisers, clock glitch filter, frame
// FSM, scan-code FIFO and the CPU-readable DATA/STATUS/CLEAR registers.
module ps2_scancode_mmio
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_scancode_mmio_if.slave bus
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       clk_sync, data_sync;
  logic             flt_clk, flt_clk_q, fall, data_s;
  logic [FLT_W-1:0] flt_cnt;

  rx_state_t        state, state_n;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_bit;
  logic [TO_W-1:0]  to_cnt;
  logic             timed_out, push, set_par, set_frm;

  logic             mem_read_q, rd_rise, pop, clr;
  logic             ovf, par_err, frm_err;
  logic [7:0]       head;
  logic             full, empty;
  logic [CW-1:0]    count;
  logic [31:0]      status_word;
  logic             unused_addr;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered clock follows the pin only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flt_clk   <= 1'b1;
      flt_clk_q <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      flt_clk_q <= flt_clk;
      if (clk_sync[1] == flt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        flt_clk <= clk_sync[1];
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall      = flt_clk_q & ~flt_clk;
  assign data_s    = data_sync[1];
  assign timed_out = (state != IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    push    = 1'b0;
    set_par = 1'b0;
    set_frm = 1'b0;
    if (timed_out) begin
      state_n = IDLE;
      set_frm = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_s) state_n = DATA;
        DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (!data_s)                            set_frm = 1'b1;
          else if (!odd_parity_ok(shreg, par_bit)) set_par = 1'b1;
          else                                     push    = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  par_bit <= data_s;
          default: ;
        endcase
      end
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign rd_rise     = bus.mem_read & ~mem_read_q;
  assign pop         = rd_rise && (bus.mem_addr[3:2] == REG_DATA) && !empty;
  assign clr         = rd_rise && (bus.mem_addr[3:2] == REG_CLEAR);
  assign unused_addr = ^{bus.mem_addr[7:4], bus.mem_addr[1:0]};

  // A new error in the same cycle as a CLEAR read survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_q <= 1'b0;
      ovf        <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      mem_read_q <= bus.mem_read;
      ovf        <= (ovf & ~clr) | (push & full & ~pop);
      par_err    <= (par_err & ~clr) | set_par;
      frm_err    <= (frm_err & ~clr) | set_frm;
    end
  end

  assign status_word = {16'b0, 8'(count), 3'b0, ovf, par_err, frm_err, full, empty};

  always_comb begin
    bus.mem_rdata = '0;
    if (bus.mem_read) begin
      case (bus.mem_addr[3:2])
        REG_DATA:   bus.mem_rdata = {23'b0, ~empty, (empty ? 8'h00 : head)};
        REG_STATUS: bus.mem_rdata = status_word;
        REG_CLEAR:  bus.mem_rdata = status_word;
        default:    bus.mem_rdata = '0;
      endcase
    end
  end

endmodule
